// File: rtl/inport_fifo.sv
// ============================================================================
// inport_fifo
// ----------------------------------------------------------------------------
// Input port for the datapath. An external producer presents a word on
// External_Input and raises strobe. Both are asynchronous to clock.
//
// Capture path:
//   - strobe goes through a two-flop synchroniser (s1 -> s2) and then a
//     history flop (s3).
//   - External_Input goes through two matching stages (d1 -> d2), so the
//     data word stays aligned with s2.
//   - A capture is taken on the synchronised rising edge of strobe.
//
// Captured words are held in a DEPTH-entry FIFO. The datapath drains one word
// per cycle that rd_en is high. The head word is shown combinationally, so the
// datapath samples it in the same cycle that it pulses rd_en.
//
// Optional build macro:
//   INPORT_DEBOUNCE_EN - strobe must stay high (after synchronisation) for
//                        DEBOUNCE_CYCLES cycles before a capture is taken.
//                        Shorter glitches are ignored.
//
// Parameters:
//   DATA_WIDTH_IN   - external input bus width
//   DATA_WIDTH_OUT  - datapath bus width. Zero-extended when wider than the
//                     input; the low bits are kept when narrower.
//   DEPTH           - number of FIFO entries (power of 2, at least 2)
//   INIT            - value shown on External_output while the FIFO is empty
//   DEBOUNCE_CYCLES - stable-high cycles before capture (debounce build only)
//
// Ports:
//   clock           in   system clock; all state changes on its rising edge
//   clear           in   synchronous active-high reset; wins over all else
//   strobe          in   async "data ready" from the external source
//   External_Input  in   async data, held stable while strobe is high
//   rd_en           in   pop request; ignored while the FIFO is empty
//   External_output out  head-of-FIFO word (show-ahead), or INIT when empty
//   data_valid      out  FIFO holds at least one word
//   full            out  count == DEPTH
//   overflow        out  sticky; a word was dropped because the FIFO was full
//   count           out  number of stored words
// ============================================================================
module inport_fifo #(
    parameter int          DATA_WIDTH_IN   = 32,
    parameter int          DATA_WIDTH_OUT  = 32,
    parameter int          DEPTH           = 4,
    parameter logic [31:0] INIT            = 32'h0,
    parameter int          DEBOUNCE_CYCLES = 4
) (
    input  logic                          clock,
    input  logic                          clear,
    input  logic                          strobe,
    input  logic [DATA_WIDTH_IN-1:0]      External_Input,
    input  logic                          rd_en,
    output logic [DATA_WIDTH_OUT-1:0]     External_output,
    output logic                          data_valid,
    output logic                          full,
    output logic                          overflow,
    output logic [$clog2(DEPTH):0]        count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Reject unusable configurations at elaboration time.
    // An illegal parameter set stops the build here, before it can fail
    // silently in hardware.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (DEBOUNCE_CYCLES < 1)
        || (DATA_WIDTH_IN < 1) || (DATA_WIDTH_OUT < 1)) begin : g_bad_param
        $error("inport_fifo: illegal parameter set");
    end

    // ------------------------------------------------------------------------
    // Synchroniser for strobe and data
    // ------------------------------------------------------------------------
    logic                     s1;
    logic                     s2;
    logic [DATA_WIDTH_IN-1:0] d1;
    logic [DATA_WIDTH_IN-1:0] d2;
    logic                     cap;

    always_ff @(posedge clock) begin
        if (clear) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            d1 <= '0;
            d2 <= '0;
        end else begin
            s1 <= strobe;
            s2 <= s1;
            d1 <= External_Input;
            d2 <= d1;
        end
    end

`ifdef INPORT_DEBOUNCE_EN
    // ------------------------------------------------------------------------
    // Debounce
    // ------------------------------------------------------------------------
    // deb_cnt counts the cycles that s2 has been high, and saturates at
    // DEBOUNCE_CYCLES. deb_done remembers that this high period has already
    // produced its capture. Without it, a saturated counter would capture
    // again on every cycle.
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES);

    logic [DW-1:0] deb_cnt;
    logic          deb_done;

    always_ff @(posedge clock) begin
        if (clear) begin
            deb_cnt  <= '0;
            deb_done <= 1'b0;
        end else if (!s2) begin
            deb_cnt  <= '0;
            deb_done <= 1'b0;
        end else begin
            if (deb_cnt != DEB_MAX) begin
                deb_cnt <= deb_cnt + DW'(1);
            end
            if (deb_cnt == DEB_MAX) begin
                deb_done <= 1'b1;
            end
        end
    end

    assign cap = s2 && (deb_cnt == DEB_MAX) && !deb_done;
`else
    // ------------------------------------------------------------------------
    // Edge detect: one capture per synchronised rising edge of strobe
    // ------------------------------------------------------------------------
    logic s3;

    always_ff @(posedge clock) begin
        if (clear) begin
            s3 <= 1'b0;
        end else begin
            s3 <= s2;
        end
    end

    // s3 is cleared by clear. So if strobe is still high when clear is
    // released, that strobe is seen as a new edge and produces a capture.
    assign cap = s2 && !s3;
`endif

    // ------------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH_IN-1:0] mem [DEPTH];
    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            rd_ptr;
    logic [CW-1:0]            count_q;
    logic                     overflow_q;

    logic empty;
    logic full_i;
    logic do_rd;
    logic do_wr;
    logic ovf_set;

    assign empty  = (count_q == '0);
    assign full_i = (count_q == CW'(DEPTH));

    // A pop is allowed whenever the FIFO holds data.
    // A push is allowed when there is room, or when the FIFO is full but a
    // pop frees a slot in the same cycle. That lets a full FIFO keep
    // streaming without setting overflow.
    // On an empty FIFO a same-cycle pop is ignored, so the pushed word stays.
    assign do_rd   = rd_en && !empty;
    assign do_wr   = cap && (!full_i || do_rd);
    assign ovf_set = cap && full_i && !rd_en;

    // Stored entries are never reset. They cannot be seen until they have
    // been rewritten.
    always_ff @(posedge clock) begin
        if (!clear && do_wr) begin
            mem[wr_ptr] <= d2;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            // DEPTH is a power of 2, so the pointers wrap by plain overflow.
            if (do_wr) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PW'(1);
            end

            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase

            if (ovf_set) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // A size cast does both width conversions: it zero-extends a narrow word
    // and keeps only the low bits of a wide one.
    logic [DATA_WIDTH_OUT-1:0] head_out;
    logic [DATA_WIDTH_OUT-1:0] init_out;

    assign head_out = DATA_WIDTH_OUT'(mem[rd_ptr]);
    assign init_out = DATA_WIDTH_OUT'(INIT);

    assign External_output = empty ? init_out : head_out;
    assign data_valid      = !empty;
    assign full            = full_i;
    assign overflow        = overflow_q;
    assign count           = count_q;

endmodule

// File: tb/tb_inport_fifo.sv
module tb_inport_fifo;

`ifdef INPORT_DEBOUNCE_EN
    localparam int DEB = 4;
`else
    localparam int DEB = 0;
`endif

    logic        clock = 1'b0;
    logic        clear;
    logic        strobe;
    logic        rd_en;
    logic [31:0] ext_in;

    logic [31:0] out32;
    logic        dv, full, ovf;
    logic [2:0]  cnt;

    logic [31:0] out16;
    logic        dv16, full16, ovf16;
    logic [2:0]  cnt16;

    logic [7:0]  out8;
    logic        dv8, full8, ovf8;
    logic [2:0]  cnt8;

    int n_checks = 0;
    int n_fail   = 0;

    inport_fifo #(.DATA_WIDTH_IN(32), .DATA_WIDTH_OUT(32), .DEPTH(4),
                  .INIT(32'h0), .DEBOUNCE_CYCLES(4)) dut (
        .clock(clock), .clear(clear), .strobe(strobe),
        .External_Input(ext_in), .rd_en(rd_en),
        .External_output(out32), .data_valid(dv), .full(full),
        .overflow(ovf), .count(cnt));

    inport_fifo #(.DATA_WIDTH_IN(16), .DATA_WIDTH_OUT(32), .DEPTH(4),
                  .INIT(32'h0), .DEBOUNCE_CYCLES(4)) dut_w16 (
        .clock(clock), .clear(clear), .strobe(strobe),
        .External_Input(ext_in[15:0]), .rd_en(rd_en),
        .External_output(out16), .data_valid(dv16), .full(full16),
        .overflow(ovf16), .count(cnt16));

    inport_fifo #(.DATA_WIDTH_IN(32), .DATA_WIDTH_OUT(8), .DEPTH(4),
                  .INIT(32'h0), .DEBOUNCE_CYCLES(4)) dut_w8 (
        .clock(clock), .clear(clear), .strobe(strobe),
        .External_Input(ext_in), .rd_en(rd_en),
        .External_output(out8), .data_valid(dv8), .full(full8),
        .overflow(ovf8), .count(cnt8));

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Strobe high long enough for one capture to land, then low long
    // enough for the next rising edge to be recognised.
    task automatic cap_word(input logic [31:0] w);
        ext_in = w;
        strobe = 1'b1;
        tick(3 + DEB);
        strobe = 1'b0;
        tick(2);
    endtask

    initial begin
        logic [31:0] exp_q [4];

        clear  = 1'b1;
        strobe = 1'b0;
        rd_en  = 1'b0;
        ext_in = 32'h0;
        tick(1);
        clear = 1'b0;
        check("reset_count", {29'b0, cnt}, 32'd0);
        check("reset_valid", {31'b0, dv}, 32'd0);
        check("reset_full", {31'b0, full}, 32'd0);
        check("reset_ovf", {31'b0, ovf}, 32'd0);
        check("reset_out", out32, 32'h0);

        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        check("empty_pop_count", {29'b0, cnt}, 32'd0);
        check("empty_pop_valid", {31'b0, dv}, 32'd0);
        check("empty_pop_out", out32, 32'h0);

        // Capture latency: strobe first sampled at edge N, word written at N+2+DEB
        ext_in = 32'hDEADBEEF;
        strobe = 1'b1;
        tick(2 + DEB);
        check("lat_valid_early", {31'b0, dv}, 32'd0);
        tick(1);
        strobe = 1'b0;
        check("lat_valid", {31'b0, dv}, 32'd1);
        check("lat_out", out32, 32'hDEADBEEF);
        check("lat_count", {29'b0, cnt}, 32'd1);
        tick(2);
        check("lat_single_cap", {29'b0, cnt}, 32'd1);
        rd_en = 1'b1;
        check("lat_pop_head", out32, 32'hDEADBEEF);
        tick(1);
        rd_en = 1'b0;
        check("lat_pop_count", {29'b0, cnt}, 32'd0);
        check("lat_pop_out", out32, 32'h0);
        check("lat_pop_valid", {31'b0, dv}, 32'd0);

        // Strobe held high for a long time yields exactly one capture
        ext_in = 32'h66;
        strobe = 1'b1;
        tick(10 + DEB);
        strobe = 1'b0;
        tick(2);
        check("held_strobe_count", {29'b0, cnt}, 32'd1);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;

        // Fill and overflow
        cap_word(32'h11);
        cap_word(32'h22);
        cap_word(32'h33);
        cap_word(32'h44);
        check("fill_full", {31'b0, full}, 32'd1);
        check("fill_ovf_clear", {31'b0, ovf}, 32'd0);
        cap_word(32'h55);
        check("ovf_count", {29'b0, cnt}, 32'd4);
        check("ovf_full", {31'b0, full}, 32'd1);
        check("ovf_set", {31'b0, ovf}, 32'd1);
        exp_q = '{32'h11, 32'h22, 32'h33, 32'h44};
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovf_drain_%0d", i), out32, exp_q[i]);
            tick(1);
        end
        rd_en = 1'b0;
        check("ovf_drain_count", {29'b0, cnt}, 32'd0);
        check("ovf_sticky", {31'b0, ovf}, 32'd1);
        check("ovf_drain_full", {31'b0, full}, 32'd0);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("ovf_cleared", {31'b0, ovf}, 32'd0);

        // Simultaneous push and pop while full
        cap_word(32'hA1);
        cap_word(32'hA2);
        cap_word(32'hA3);
        cap_word(32'hA4);
        ext_in = 32'hA5;
        strobe = 1'b1;
        tick(2 + DEB);
        rd_en = 1'b1;
        check("full_pp_head", out32, 32'hA1);
        tick(1);
        rd_en  = 1'b0;
        strobe = 1'b0;
        check("full_pp_count", {29'b0, cnt}, 32'd4);
        check("full_pp_ovf", {31'b0, ovf}, 32'd0);
        check("full_pp_full", {31'b0, full}, 32'd1);
        tick(2);
        exp_q = '{32'hA2, 32'hA3, 32'hA4, 32'hA5};
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("full_pp_drain_%0d", i), out32, exp_q[i]);
            tick(1);
        end
        rd_en = 1'b0;
        check("full_pp_empty", {29'b0, cnt}, 32'd0);

        // Simultaneous push and pop while empty: write wins, read ignored
        ext_in = 32'hB1;
        strobe = 1'b1;
        tick(2 + DEB);
        rd_en = 1'b1;
        tick(1);
        rd_en  = 1'b0;
        strobe = 1'b0;
        check("empty_pp_count", {29'b0, cnt}, 32'd1);
        check("empty_pp_out", out32, 32'hB1);
        tick(2);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;

        // Clear wins over a same-cycle capture; a still-high strobe recaptures
        ext_in = 32'h77;
        strobe = 1'b1;
        tick(2 + DEB);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("clr_prio_count", {29'b0, cnt}, 32'd0);
        check("clr_prio_valid", {31'b0, dv}, 32'd0);
        tick(3 + DEB);
        check("clr_recap_count", {29'b0, cnt}, 32'd1);
        check("clr_recap_out", out32, 32'h77);
        strobe = 1'b0;
        tick(2);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;

        // Width conversion
        cap_word(32'h1234A5A5);
        cap_word(32'h12345678);
        check("w16_zero_ext", out16, 32'h0000A5A5);
        check("w8_trunc_a", {24'b0, out8}, 32'hA5);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        check("w16_zero_ext_b", out16, 32'h00005678);
        check("w8_trunc_b", {24'b0, out8}, 32'h78);
        check("w32_b", out32, 32'h12345678);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        check("w8_init", {24'b0, out8}, 32'h0);
        check("w16_count", {29'b0, cnt16}, 32'd0);

`ifdef INPORT_DEBOUNCE_EN
        // Short glitch: no capture
        ext_in = 32'hC1;
        strobe = 1'b1;
        tick(2);
        strobe = 1'b0;
        tick(8);
        check("deb_glitch", {29'b0, cnt}, 32'd0);
        // Clear in the middle of debouncing: no capture
        strobe = 1'b1;
        tick(4);
        clear = 1'b1;
        tick(1);
        clear  = 1'b0;
        strobe = 1'b0;
        tick(8);
        check("deb_clear_mid", {29'b0, cnt}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inport_fifo.md
Name: inport_fifo

Overview:
- Next-generation input port for the datapath.
- Captures an external word on a rising edge of an external strobe. The strobe and data are synchronised into the `clock` domain first.
- Captured words are buffered in a parametrised FIFO. The CPU datapath drains it one word per `rd_en` pulse.
- Replaces the single level-sensitive input latch. Adds width conversion, buffering, full/overflow status and synchronous clear.

Parameters:
- DATA_WIDTH_IN, 32, width of the external input bus.
- DATA_WIDTH_OUT, 32, width presented to the datapath bus. Zero-extended if wider than DATA_WIDTH_IN, low bits kept if narrower.
- DEPTH, 4, FIFO entries. Must be a power of 2 and at least 2.
- INIT, 32'h0, value driven on External_output while the FIFO is empty (low DATA_WIDTH_OUT bits used).
- DEBOUNCE_CYCLES, 4, stable-high cycles required before capture. Used only with INPORT_DEBOUNCE_EN.

Ports:
- clock, input, 1, system clock. All state updates on its rising edge.
- clear, input, 1, synchronous active-high reset.
- strobe, input, 1, asynchronous external "data ready" signal.
- External_Input, input, DATA_WIDTH_IN, asynchronous external data. Held stable by the source while strobe is high.
- rd_en, input, 1, datapath pop request. One word popped per cycle it is high and the FIFO is non-empty.
- External_output, output, DATA_WIDTH_OUT, head-of-FIFO word (show-ahead), or INIT when empty.
- data_valid, output, 1, FIFO non-empty.
- full, output, 1, count == DEPTH.
- overflow, output, 1, sticky. A capture occurred while full with no simultaneous pop.
- count, output, $clog2(DEPTH)+1, number of stored words.

Behaviour:
- Reset: clear is synchronous and active-high, sampled on the rising edge of clock. It has priority over every other event, including a capture or pop in the same cycle. After the edge:
  - pointers, count and synchroniser flops = 0
  - data_valid = 0, full = 0, overflow = 0
  - External_output = INIT
  - stored entries are not cleared (unobservable)
- Synchroniser: strobe passes through two flops, s1 then s2, plus a history flop s3. External_Input is registered through two matching stages, d1 then d2, so data stays aligned with s2.
- Capture pulse `cap` is s2 & ~s3 (one cycle per rising edge).
- Latency: strobe high before edge N → s2 high after edge N+1 → word d2 written at edge N+2 → data_valid high after edge N+2.
- Write on cap: if not full, mem[wr_ptr] ← d2, wr_ptr increments. If full and rd_en is low, the word is dropped and overflow ← 1; overflow holds until clear.
- Read on rd_en: if data_valid, rd_ptr increments. If empty, rd_en is ignored and nothing changes.
- External_output is combinational from mem[rd_ptr] after width conversion. It is not registered, so the datapath samples it in the same cycle as rd_en.
- Simultaneous cap and rd_en:
  - non-empty (including full): both occur and count is unchanged; no overflow is set when full.
  - empty: the write occurs and the read is ignored, so count becomes 1.
- Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 naturally.
- count and full are derived from count; count never exceeds DEPTH or underflows.
- A strobe that stays high produces exactly one capture. A new capture needs strobe low for at least one synchronised cycle.
- A strobe pulse shorter than one clock period may be missed; the source is required to hold strobe for at least 2 cycles.
- clear asserted mid-operation discards all buffered words and any pending synchroniser state. A strobe still high after clear deasserts produces a capture, because s3 reset to 0.

Optional Feature:
- Macro: INPORT_DEBOUNCE_EN.
- Defined:
  - A counter of $clog2(DEBOUNCE_CYCLES+1) bits increments while s2 is high, saturating at DEBOUNCE_CYCLES, and resets to 0 whenever s2 is low.
  - cap fires for one cycle only when the counter reaches DEBOUNCE_CYCLES.
  - Capture latency becomes N+2+DEBOUNCE_CYCLES.
  - Glitches shorter than DEBOUNCE_CYCLES synchronised cycles produce no capture.
  - The captured data is d2 at the cycle cap fires.
- Undefined: no counter; cap = s2 & ~s3 as above. DEBOUNCE_CYCLES is unused.

Test Plan:
- Reset and empty state: assert clear 1 cycle → count=0, data_valid=0, full=0, overflow=0, External_output=32'h0. Then pulse rd_en → all outputs unchanged.
- Single capture latency: drive External_Input=32'hDEADBEEF, strobe high 3 cycles from edge N → data_valid rises after edge N+2, External_output=32'hDEADBEEF, count=1. Pulse rd_en → count=0, output returns to INIT.
- Fill and overflow (DEPTH=4): capture 0x11, 0x22, 0x33, 0x44, then 0x55 → full=1, count=4, overflow=1. Pop 4 times → outputs in order 0x11, 0x22, 0x33, 0x44 (0x55 dropped); overflow stays 1 until clear.
- Simultaneous push/pop when full: with 4 entries, cap and rd_en in the same cycle → count stays 4, overflow stays 0, head advances to the 2nd word, the new word lands at the tail, and pointers wrap correctly.
- Width conversion: DATA_WIDTH_IN=16, DATA_WIDTH_OUT=32, capture 16'hA5A5 → External_output=32'h0000A5A5. With DATA_WIDTH_IN=32, DATA_WIDTH_OUT=8, capture 32'h12345678 → 8'h78.
- Debounce (INPORT_DEBOUNCE_EN, DEBOUNCE_CYCLES=4): strobe high 2 cycles → no capture. Strobe high 8 cycles → exactly one capture, data_valid after edge N+6. Clear mid-debounce → counter zeroed, no capture.
